datastore_buf: RTL and testbench

- Parametrised successor to the PS/2 byte store.
- Appends incoming bytes at an auto-incrementing write pointer, supports backspace and clear, and exposes all stored bytes on a flat parallel bus.
- Adds occupancy/full/overflow status and a non-destructive byte-serial readout with a valid/ready handshake, so the cipher or display path can stream the message out.
- Sits between the PS/2 keyboard decoder and the encrypt/decrypt datapath.

---
 rtl/datastore_buf.sv | 169 ++++++++++++++++
 tb/tb_datastore_buf.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/datastore_buf.sv
// Byte store: append/backspace/clear, flat parallel view, status flags and a
// non-destructive valid/ready serial readout. DATASTORE_INDEXED_EN adds random-slot writes.
module datastore_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 28,
  parameter int CNT_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    bksp,
  input  logic                    clear,
`ifdef DATASTORE_INDEXED_EN
  input  logic                    wr_idx_en,
  input  logic [CNT_W-1:0]        wr_idx,
`endif
  input  logic                    rd_start,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_last,
  output logic                    busy,
  output logic [CNT_W-1:0]        count,
  output logic                    empty,
  output logic                    full,
  output logic                    overflow,
  output logic [DATA_W*DEPTH-1:0] datastore_out
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_slots [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_rd_idx;
  logic              r_overflow;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic [DATA_W-1:0] r_rd_data;

  logic w_full, w_empty, w_xfer;
  logic w_do_bksp, w_do_wr, w_do_idx, w_do_ovf, w_do_start, w_do_adv, w_do_end;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_xfer  = r_rd_valid && rd_ready;

  // Priority chain: clear > bksp > indexed write > wr_en > rd_start; STREAM only handshakes.
  always_comb begin
    w_state_nxt = r_state;
    w_do_bksp   = 1'b0;
    w_do_wr     = 1'b0;
    w_do_idx    = 1'b0;
    w_do_ovf    = 1'b0;
    w_do_start  = 1'b0;
    w_do_adv    = 1'b0;
    w_do_end    = 1'b0;
    if (clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bksp) begin
            w_do_bksp = !w_empty;
`ifdef DATASTORE_INDEXED_EN
          end else if (wr_idx_en) begin
            if (wr_idx < CNT_W'(DEPTH)) w_do_idx = 1'b1;
            else                        w_do_ovf = 1'b1;
`endif
          end else if (wr_en) begin
            if (w_full) w_do_ovf = 1'b1;
            else        w_do_wr  = 1'b1;
          end else if (rd_start && !w_empty) begin
            w_do_start  = 1'b1;
            w_state_nxt = S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (r_rd_last) begin
              w_do_end    = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_do_adv = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_slots[k] <= '0;
      r_count    <= '0;
      r_rd_idx   <= '0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else if (clear) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_slots[k] <= '0;
      r_count    <= '0;
      r_rd_idx   <= '0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (w_do_bksp) begin
        r_slots[r_count - 1'b1] <= '0;
        r_count                 <= r_count - 1'b1;
      end
      if (w_do_wr) begin
        r_slots[r_count] <= wr_data;
        r_count          <= r_count + 1'b1;
      end
`ifdef DATASTORE_INDEXED_EN
      if (w_do_idx) begin
        r_slots[wr_idx] <= wr_data;
        if (wr_idx >= r_count) r_count <= wr_idx + 1'b1;
      end
`endif
      if (w_do_ovf) r_overflow <= 1'b1;
      if (w_do_start) begin
        r_rd_idx   <= '0;
        r_rd_valid <= 1'b1;
        r_rd_data  <= r_slots[0];
        r_rd_last  <= (r_count == CNT_W'(1));
      end
      if (w_do_adv) begin
        r_rd_idx  <= r_rd_idx + 1'b1;
        r_rd_data <= r_slots[r_rd_idx + 1'b1];
        r_rd_last <= ((r_rd_idx + CNT_W'(2)) == r_count);
      end
      if (w_do_end) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
    end
  end

  always_comb begin
    datastore_out = '0;
    for (int unsigned k = 0; k < DEPTH; k++) datastore_out[DATA_W*k +: DATA_W] = r_slots[k];
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_last  = r_rd_last;
  assign busy     = (r_state == S_STREAM);
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;
  assign overflow = r_overflow;

`ifndef DATASTORE_INDEXED_EN
  logic w_unused;
  assign w_unused = w_do_idx;
`endif

endmodule

// File: tb/tb_datastore_buf.sv
// Bench for datastore_buf: directed steps then random traffic against a queue-based model.
// Honours DATASTORE_INDEXED_EN when defined.
module tb_datastore_buf;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 28;
  localparam int CNT_W  = 5;
  localparam int FW     = DATA_W * DEPTH;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0, bksp = 1'b0, clear = 1'b0, rd_start = 1'b0, rd_ready = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_valid, rd_last, busy, empty, full, overflow;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  count;
  logic [FW-1:0]     datastore_out;
`ifdef DATASTORE_INDEXED_EN
  logic              wr_idx_en = 1'b0;
  logic [CNT_W-1:0]  wr_idx = '0;
`endif

  datastore_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .bksp(bksp), .clear(clear),
`ifdef DATASTORE_INDEXED_EN
    .wr_idx_en(wr_idx_en), .wr_idx(wr_idx),
`endif
    .rd_start(rd_start), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .busy(busy), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .datastore_out(datastore_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: stored message as a queue, plus stream cursor.
  logic [DATA_W-1:0] m_store[$];
  logic              m_ovf = 1'b0;
  logic              m_stream = 1'b0;
  int                m_pos = 0;

  logic [DATA_W-1:0] acc_data[$];
  logic              acc_last[$];

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] m_flat();
    logic [FW-1:0] f = '0;
    for (int k = 0; k < m_store.size(); k++) f[DATA_W*k +: DATA_W] = m_store[k];
    return f;
  endfunction

  task automatic model_reset();
    m_store.delete();
    m_ovf    = 1'b0;
    m_stream = 1'b0;
    m_pos    = 0;
  endtask

  task automatic model_step();
    if (clear) begin
      model_reset();
    end else if (m_stream) begin
      if (rd_ready) begin
        if (m_pos == m_store.size() - 1) m_stream = 1'b0;
        else m_pos++;
      end
    end else if (bksp) begin
      if (m_store.size() > 0) void'(m_store.pop_back());
`ifdef DATASTORE_INDEXED_EN
    end else if (wr_idx_en) begin
      if (int'(wr_idx) < DEPTH) begin
        while (m_store.size() <= int'(wr_idx)) m_store.push_back('0);
        m_store[wr_idx] = wr_data;
      end else m_ovf = 1'b1;
`endif
    end else if (wr_en) begin
      if (m_store.size() < DEPTH) m_store.push_back(wr_data);
      else m_ovf = 1'b1;
    end else if (rd_start && m_store.size() > 0) begin
      m_stream = 1'b1;
      m_pos    = 0;
    end
  endtask

  task automatic check_all();
    chk("count", FW'(count), FW'(m_store.size()));
    chk("empty", FW'(empty), FW'(m_store.size() == 0));
    chk("full", FW'(full), FW'(m_store.size() == DEPTH));
    chk("overflow", FW'(overflow), FW'(m_ovf));
    chk("busy", FW'(busy), FW'(m_stream));
    chk("rd_valid", FW'(rd_valid), FW'(m_stream));
    chk("rd_last", FW'(rd_last), FW'(m_stream && (m_pos == m_store.size() - 1)));
    if (m_stream) chk("rd_data", FW'(rd_data), FW'(m_store[m_pos]));
    chk("datastore_out", datastore_out, m_flat());
  endtask

  // One clock: log handshakes, advance the model on the edge, check 1ns later.
  task automatic cyc();
    if (rd_valid && rd_ready) begin
      acc_data.push_back(rd_data);
      acc_last.push_back(rd_last);
    end
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_in();
    wr_en = 0; bksp = 0; clear = 0; rd_start = 0; rd_ready = 0;
`ifdef DATASTORE_INDEXED_EN
    wr_idx_en = 0;
`endif
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    idle_in(); wr_en = 1; wr_data = d; cyc(); idle_in();
  endtask

  task automatic do_clear();
    idle_in(); clear = 1; cyc(); idle_in();
  endtask

  task automatic async_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    if (!((1 << CNT_W) > DEPTH)) $fatal(1, "FAIL param CNT_W too small for DEPTH");

    // Reset state
    idle_in();
    #12;
    model_reset();
    check_all();
    @(posedge clk); #1;
    reset = 1'b0;
    cyc();

    // Three appends
    wr(8'h41); wr(8'h42); wr(8'h43);
    chk("abc_low24", FW'(datastore_out[23:0]), FW'(24'h434241));

    // Fill to capacity then overflow
    do_clear();
    for (int i = 1; i <= DEPTH; i++) wr(DATA_W'(i));
    wr(8'hFF);
    chk("slot27", FW'(datastore_out[DATA_W*27 +: DATA_W]), FW'(8'h1C));
    chk("full_ovf", FW'({full, overflow, count}), FW'({1'b1, 1'b1, 5'd28}));

    // Backspace, and bksp+wr_en together drops the write
    do_clear();
    wr(8'h41); wr(8'h42);
    bksp = 1; cyc(); idle_in();
    bksp = 1; wr_en = 1; wr_data = 8'h55; cyc(); idle_in();
    chk("bksp_count", FW'(count), FW'(0));
    chk("bksp_low16", FW'(datastore_out[15:0]), FW'(0));

    // Stream with ready pattern 1,0,1,1
    do_clear();
    acc_data.delete(); acc_last.delete();
    wr(8'h10); wr(8'h20); wr(8'h30);
    rd_start = 1; cyc(); rd_start = 0;
    rd_ready = 1; cyc();
    rd_ready = 0; cyc();
    rd_ready = 1; cyc();
    rd_ready = 1; cyc();
    rd_ready = 0;
    for (int i = 0; i < 8 && rd_valid; i++) cyc();
    chk("stream_n", FW'(acc_data.size()), FW'(3));
    if (acc_data.size() == 3) begin
      chk("stream_b0", FW'({acc_data[0], acc_last[0]}), FW'({8'h10, 1'b0}));
      chk("stream_b1", FW'({acc_data[1], acc_last[1]}), FW'({8'h20, 1'b0}));
      chk("stream_b2", FW'({acc_data[2], acc_last[2]}), FW'({8'h30, 1'b1}));
    end
    chk("stream_count", FW'(count), FW'(3));

    // Mid-stream clear, then rd_start on an empty store
    rd_start = 1; cyc(); rd_start = 0;
    do_clear();
    rd_start = 1; cyc(); rd_start = 0;
    cyc();
    chk("empty_start", FW'(rd_valid), FW'(0));

    // Mid-stream async reset
    wr(8'hA1); wr(8'hA2);
    rd_start = 1; cyc(); rd_start = 0;
    async_reset();
    cyc();

`ifdef DATASTORE_INDEXED_EN
    wr(8'h01); wr(8'h02);
    wr_idx_en = 1; wr_idx = 5; wr_data = 8'h7E; cyc(); idle_in();
    chk("idx_slot5", FW'(datastore_out[DATA_W*5 +: DATA_W]), FW'(8'h7E));
    chk("idx_count", FW'(count), FW'(6));
    wr_idx_en = 1; wr_idx = 30; wr_data = 8'h11; cyc(); idle_in();
    chk("idx_ovf", FW'(overflow), FW'(1));
`endif

    // Random traffic against the model
    do_clear();
    for (int n = 0; n < 600; n++) begin
      int r;
      idle_in();
      r = int'($urandom_range(0, 99));
      if (r < 2) clear = 1;
      else if (r < 10) bksp = 1;
`ifdef DATASTORE_INDEXED_EN
      else if (r < 15) begin wr_idx_en = 1; wr_idx = CNT_W'($urandom_range(0, 31)); end
`endif
      else if (r < 60) wr_en = 1;
      else if (r < 75) rd_start = 1;
      if ($urandom_range(0, 9) == 0) wr_en = 1;
      wr_data  = DATA_W'($urandom);
      rd_ready = 1'($urandom);
      if (n == 300) async_reset();
      else cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
